histogram_lut_builder: RTL and testbench
========================================

Name: histogram_lut_builder

Overview:
- Sits directly downstream of histogram_calculator.
- After each frame, sweeps the calculator's external read port over bins 0..255 and accumulates the cumulative distribution (CDF).
- Converts the CDF into a 256-entry histogram-equalisation LUT.
- Applies the LUT to the incoming pixel stream with 1-cycle latency, forwarding the sync signals alongside.

Parameters:
- FRAME_LOG2, 8, log2 of active pixels per frame; scale shift for the CDF.
- CDF_W, 24, CDF accumulator width.
- RD_TIMEOUT, 16, max cycles to wait for hist_valid per bin request.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: histogram of previous frame complete (driven from end_of_frame/vs)
- hist_addr_rd  out  8  bin address to histogram_calculator external_addr_rd
- hist_data_rd  in  16  bin count from external_data_rd
- hist_valid  in  1  qualifies hist_data_rd (calculator out_valid)
- in_pixel  in  8  luma in
- in_valid  in  1  data valid in
- in_hs  in  1  hsync in
- in_vs  in  1  vsync in
- out_pixel  out  8  mapped luma
- out_valid  out  1  delayed in_valid
- out_hs  out  1  delayed in_hs
- out_vs  out  1  delayed in_vs
- busy  out  1  LUT build in progress
- lut_ready  out  1  at least one LUT completed since reset
- rd_err  out  1  sticky: read timeout occurred; cleared by rst or next start

Behaviour:
- Reset values: hist_addr_rd=0, out_pixel=0, out_valid=0, out_hs=0, out_vs=0, busy=0, lut_ready=0, rd_err=0, FSM=IDLE, cdf=0. LUT RAM contents are not cleared.
- FSM IDLE:
  - start=1 -> REQ; cdf<=0, bin<=0, busy<=1, rd_err<=0.
  - start while busy is ignored.
- FSM REQ:
  - drive hist_addr_rd=bin, clear timeout counter -> WAIT.
- FSM WAIT:
  - hist_valid=1 -> cdf_next = cdf + hist_data_rd (saturate at 2^CDF_W-1).
  - lut[bin] <= min(255, (cdf_next*255) >> FRAME_LOG2) -> ACC.
  - Timeout counter reaching RD_TIMEOUT -> rd_err<=1, busy<=0 -> IDLE; lut_ready unchanged; partially written bank is not committed.
- FSM ACC:
  - bin==255 -> DONE; else bin<=bin+1 -> REQ.
  - bin wrap 255->0 never occurs inside a build.
- FSM DONE:
  - lut_ready<=1, busy<=0, commit bank -> IDLE.
  - Sweep length is ≥3*256 cycles.
- hist_valid while not in WAIT is ignored.
- Arithmetic: product width CDF_W+8; shift is logical. Result must be monotonic non-decreasing across bins.
- Pixel path, fixed latency 1 cycle for all of out_pixel, out_valid, out_hs, out_vs:
  - lut_ready=0 -> out_pixel=in_pixel (identity).
  - lut_ready=1 -> out_pixel=lut_active[in_pixel].
  - When in_valid=0, out_pixel is held at its previous value.
- Simultaneous LUT write and pixel read: reads use the active bank only (see optional feature); no read-during-write hazard on the active bank.
- rst mid-build: return to IDLE next cycle; lut_ready=0, so output reverts to identity.

Optional Feature:
- Macro: HEQ_LUT_DOUBLE_BUFFER_EN.
- Defined:
  - Two LUT banks; the build writes the inactive bank.
  - DONE toggles the active bank select on the same cycle lut_ready is set.
  - Mapping of the previous frame stays in use during the build; a timeout leaves the old bank active.
- Undefined:
  - Single bank, written in place.
  - While busy=1, out_pixel=in_pixel (identity) regardless of lut_ready, avoiding mixed old/new mappings.

Test Plan:
- Flat histogram (every bin=1, FRAME_LOG2=8), start pulse -> busy high ≥768 cycles, lut_ready=1; lut[k]=((k+1)*255)>>8, e.g. lut[0]=0, lut[255]=255; in_pixel 0x80 -> out_pixel 0x80 one cycle later.
- All 256 pixels in bin 0x10 -> lut[0..15]=0, lut[16..255]=255; pixel 0x05 -> 0x00, pixel 0x10 -> 0xFF; out_valid/out_hs/out_vs equal inputs delayed 1 cycle.
- hist_valid withheld on bin 7 -> rd_err=1 after 16 cycles, busy=0; with HEQ_LUT_DOUBLE_BUFFER_EN the previous mapping remains in effect; next start clears rd_err.
- Second start pulse during busy -> ignored; sweep completes at the original timing.
- rst asserted at bin 100 -> next cycle busy=0, lut_ready=0, out_pixel tracks in_pixel (identity).
- Without the macro, stream pixels during a build -> out_pixel==in_pixel while busy=1; the new mapping applies from the first pixel after busy falls.

Source files
------------

// File: rtl/histogram_lut_builder_if.sv
// Histogram read port and pixel stream bundle for histogram_lut_builder.
// The builder drives the read address and the mapped pixel stream (slave modport).
interface histogram_lut_builder_if;
    logic [7:0]  hist_addr_rd;
    logic [15:0] hist_data_rd;
    logic        hist_valid;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_hs;
    logic        in_vs;
    logic [7:0]  out_pixel;
    logic        out_valid;
    logic        out_hs;
    logic        out_vs;

    modport master (
        output hist_data_rd, hist_valid, in_pixel, in_valid, in_hs, in_vs,
        input  hist_addr_rd, out_pixel, out_valid, out_hs, out_vs
    );

    modport slave (
        input  hist_data_rd, hist_valid, in_pixel, in_valid, in_hs, in_vs,
        output hist_addr_rd, out_pixel, out_valid, out_hs, out_vs
    );
endinterface

// File: rtl/histogram_lut_builder.sv
// Builds a histogram-equalisation LUT from the calculator's bins and maps the pixel stream.
// Optional HEQ_LUT_DOUBLE_BUFFER_EN: two LUT banks, build writes the inactive one.
module histogram_lut_builder #(
    parameter int unsigned FRAME_LOG2 = 8,
    parameter int unsigned CDF_W      = 24,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    histogram_lut_builder_if.slave  bus,
    output logic                    busy,
    output logic                    lut_ready,
    output logic                    rd_err
);
    localparam int unsigned SUM_W  = CDF_W + 1;
    localparam int unsigned PROD_W = CDF_W + 8;
    localparam int unsigned TMO_W  = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACC, S_DONE} state_t;

    state_t             state;
    logic [7:0]         bin;
    logic [CDF_W-1:0]   cdf;
    logic [TMO_W-1:0]   tmo;

    logic [SUM_W-1:0]   cdf_sum_c;
    logic [CDF_W-1:0]   cdf_next_c;
    logic [PROD_W-1:0]  scaled_c;
    logic [7:0]         lut_val_c;
    logic               lut_we_c;
    logic [7:0]         map_c;
    logic               identity_c;

    // Saturating CDF step and scaled, clamped LUT entry for the current bin
    always_comb begin
        cdf_sum_c  = {1'b0, cdf} + SUM_W'(bus.hist_data_rd);
        cdf_next_c = cdf_sum_c[CDF_W] ? {CDF_W{1'b1}} : cdf_sum_c[CDF_W-1:0];
        scaled_c   = (PROD_W'(cdf_next_c) * PROD_W'(255)) >> FRAME_LOG2;
        lut_val_c  = (scaled_c > PROD_W'(255)) ? 8'hFF : scaled_c[7:0];
        lut_we_c   = (state == S_WAIT) && bus.hist_valid && !rst;
    end

`ifdef HEQ_LUT_DOUBLE_BUFFER_EN
    logic [7:0] lut_mem [0:1][0:255];
    logic       bank_sel;

    always_ff @(posedge clk) begin
        if (lut_we_c)
            lut_mem[~bank_sel][bin] <= lut_val_c;
    end

    // Active bank flips only when a complete build is committed
    always_ff @(posedge clk) begin
        if (rst)
            bank_sel <= 1'b0;
        else if (state == S_DONE)
            bank_sel <= ~bank_sel;
    end

    assign map_c      = lut_mem[bank_sel][bus.in_pixel];
    assign identity_c = !lut_ready;
`else
    logic [7:0] lut_mem [0:255];

    always_ff @(posedge clk) begin
        if (lut_we_c)
            lut_mem[bin] <= lut_val_c;
    end

    // In-place rebuild: pass pixels through while the table is half old, half new
    assign map_c      = lut_mem[bus.in_pixel];
    assign identity_c = !lut_ready || busy;
`endif

    // Bin sweep controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            bin              <= 8'd0;
            cdf              <= '0;
            tmo              <= '0;
            bus.hist_addr_rd <= 8'd0;
            busy             <= 1'b0;
            lut_ready        <= 1'b0;
            rd_err           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_REQ;
                        cdf    <= '0;
                        bin    <= 8'd0;
                        busy   <= 1'b1;
                        rd_err <= 1'b0;
                    end
                end
                S_REQ: begin
                    bus.hist_addr_rd <= bin;
                    tmo              <= '0;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.hist_valid) begin
                        cdf   <= cdf_next_c;
                        state <= S_ACC;
                    end else if (tmo == TMO_W'(RD_TIMEOUT - 1)) begin
                        rd_err <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                S_ACC: begin
                    if (bin == 8'hFF) begin
                        state <= S_DONE;
                    end else begin
                        bin   <= bin + 8'd1;
                        state <= S_REQ;
                    end
                end
                S_DONE: begin
                    lut_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // One-cycle pixel path with sync pass-through
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_pixel <= 8'd0;
            bus.out_valid <= 1'b0;
            bus.out_hs    <= 1'b0;
            bus.out_vs    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            bus.out_hs    <= bus.in_hs;
            bus.out_vs    <= bus.in_vs;
            if (bus.in_valid)
                bus.out_pixel <= identity_c ? bus.in_pixel : map_c;
        end
    end
endmodule

// File: tb/tb_histogram_lut_builder.sv
// Self-checking bench for histogram_lut_builder: vector tables, timed build sequences
// and random histograms checked against a CDF-based reference LUT.
module tb_histogram_lut_builder;
    localparam int unsigned FRAME_LOG2 = 8;
    localparam int unsigned CDF_W      = 24;
    localparam longint unsigned CDF_MAX = (64'd1 << CDF_W) - 64'd1;
`ifdef HEQ_LUT_DOUBLE_BUFFER_EN
    localparam bit SINGLE = 1'b0;
`else
    localparam bit SINGLE = 1'b1;
`endif

    typedef struct {
        logic [7:0] pix;
        logic       v, hs, vs;
        logic [7:0] e_pix;
        logic       e_v, e_hs, e_vs;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, lut_ready, rd_err;

    histogram_lut_builder_if bus();

    histogram_lut_builder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .lut_ready (lut_ready),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;

    // Histogram source: answers any address, can withhold one bin or stall randomly
    logic [15:0] hist [256];
    logic        rnd_lat = 1'b0;
    logic        rnd_ok  = 1'b1;
    logic        bad_en  = 1'b0;
    logic [7:0]  bad_bin = 8'd7;

    assign bus.hist_data_rd = hist[bus.hist_addr_rd];
    assign bus.hist_valid   = rnd_ok && !(bad_en && bus.hist_addr_rd == bad_bin);

    always @(negedge clk) rnd_ok = rnd_lat ? ($urandom_range(0, 3) != 0) : 1'b1;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  mdl_lut [256];
    logic [7:0]  nxt_lut [256];
    bit          mdl_ready = 1'b0;
    logic [7:0]  exp_prev  = 8'd0;
    vec_t        flat_tab  [6];
    vec_t        spike_tab [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: running CDF, saturated, scaled by 255 / 2^FRAME_LOG2, clamped
    task automatic ref_lut();
        longint unsigned cdf = 0;
        longint unsigned v;
        for (int b = 0; b < 256; b++) begin
            cdf = cdf + 64'(hist[b]);
            if (cdf > CDF_MAX) cdf = CDF_MAX;
            v = (cdf * 64'd255) >> FRAME_LOG2;
            nxt_lut[b] = (v > 64'd255) ? 8'hFF : 8'(v);
        end
    endtask

    task automatic set_hist(input int mode);
        for (int b = 0; b < 256; b++) begin
            case (mode)
                0: hist[b] = 16'd1;
                1: hist[b] = (b == 16) ? 16'd256 : 16'd0;
                2: hist[b] = 16'($urandom_range(0, 2));
                default: hist[b] = 16'($urandom_range(0, 65535));
            endcase
        end
        ref_lut();
    endtask

    task automatic commit_model();
        for (int b = 0; b < 256; b++) mdl_lut[b] = nxt_lut[b];
        mdl_ready = 1'b1;
    endtask

    // One pixel cycle: drive at negedge, compare one cycle later at negedge
    task automatic cyc(input logic [7:0] p, input logic v, input logic hs, input logic vs,
                       input bit forced_id);
        logic [7:0] e;
        bus.in_pixel = p;
        bus.in_valid = v;
        bus.in_hs    = hs;
        bus.in_vs    = vs;
        e = !v ? exp_prev : ((forced_id || !mdl_ready) ? p : mdl_lut[p]);
        @(posedge clk);
        @(negedge clk);
        chk("out_pixel", 32'(bus.out_pixel), 32'(e));
        chk("out_valid", 32'(bus.out_valid), 32'(v));
        chk("out_hs",    32'(bus.out_hs),    32'(hs));
        chk("out_vs",    32'(bus.out_vs),    32'(vs));
        exp_prev = e;
    endtask

    task automatic rnd_cyc(input bit forced_id);
        cyc(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), forced_id);
    endtask

    task automatic sweep();
        for (int p = 0; p < 256; p++)
            cyc(8'(p), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic apply_tab(input vec_t t);
        bus.in_pixel = t.pix;
        bus.in_valid = t.v;
        bus.in_hs    = t.hs;
        bus.in_vs    = t.vs;
        @(posedge clk);
        @(negedge clk);
        chk("tab_pixel", 32'(bus.out_pixel), 32'(t.e_pix));
        chk("tab_valid", 32'(bus.out_valid), 32'(t.e_v));
        chk("tab_hs",    32'(bus.out_hs),    32'(t.e_hs));
        chk("tab_vs",    32'(bus.out_vs),    32'(t.e_vs));
        exp_prev = t.e_pix;
    endtask

    // Fixed-latency build (hist always valid): 3 cycles per bin, busy drops 769 edges after start
    task automatic run_build(input bit dup);
        start = 1'b1;
        cyc(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int k = 1; k <= 769; k++) begin
            if (dup && k == 100) start = 1'b1;
            rnd_cyc(SINGLE);
            start = 1'b0;
            if (k == 768) chk("busy_at_768", 32'(busy), 32'd1);
            if (k == 769) begin
                chk("busy_at_769", 32'(busy), 32'd0);
                chk("ready_at_769", 32'(lut_ready), 32'd1);
                chk("no_rd_err", 32'(rd_err), 32'd0);
            end
        end
        commit_model();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("build_within_budget", 32'(busy), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Flat histogram gives the identity mapping
        flat_tab[0] = '{8'h00, 1, 0, 0, 8'h00, 1, 0, 0};
        flat_tab[1] = '{8'hFF, 1, 1, 0, 8'hFF, 1, 1, 0};
        flat_tab[2] = '{8'h80, 1, 0, 1, 8'h80, 1, 0, 1};
        flat_tab[3] = '{8'h3C, 0, 1, 1, 8'h80, 0, 1, 1};
        flat_tab[4] = '{8'h0F, 1, 0, 0, 8'h0F, 1, 0, 0};
        flat_tab[5] = '{8'h7F, 1, 1, 1, 8'h7F, 1, 1, 1};
        // All 256 pixels in bin 0x10: step from 0x00 to 0xFF at 0x10
        spike_tab[0] = '{8'h05, 1, 1, 0, 8'h00, 1, 1, 0};
        spike_tab[1] = '{8'h10, 1, 0, 1, 8'hFF, 1, 0, 1};
        spike_tab[2] = '{8'h0F, 1, 0, 0, 8'h00, 1, 0, 0};
        spike_tab[3] = '{8'h11, 0, 1, 1, 8'h00, 0, 1, 1};
        spike_tab[4] = '{8'hFF, 1, 0, 0, 8'hFF, 1, 0, 0};
        spike_tab[5] = '{8'h00, 1, 1, 1, 8'h00, 1, 1, 1};
        spike_tab[6] = '{8'h20, 0, 0, 0, 8'h00, 0, 0, 0};
        spike_tab[7] = '{8'h80, 1, 0, 0, 8'hFF, 1, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        bus.in_pixel = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_hs = 1'b0;
        bus.in_vs = 1'b0;
        set_hist(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",      32'(bus.hist_addr_rd), 32'd0);
        chk("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_hs",    32'(bus.out_hs), 32'd0);
        chk("rst_out_vs",    32'(bus.out_vs), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_lut_ready", 32'(lut_ready), 32'd0);
        chk("rst_rd_err",    32'(rd_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) rnd_cyc(1'b0);

        set_hist(0);
        run_build(1'b0);
        foreach (flat_tab[i]) apply_tab(flat_tab[i]);

        set_hist(1);
        run_build(1'b1);
        foreach (spike_tab[i]) apply_tab(spike_tab[i]);

        // Random histograms with random read latency
        rnd_lat = 1'b1;
        for (int r = 0; r < 3; r++) begin
            set_hist((r == 2) ? 3 : 2);
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk("rnd_busy", 32'(busy), 32'd1);
            wait_idle(4000);
            chk("rnd_ready", 32'(lut_ready), 32'd1);
            commit_model();
            sweep();
        end
        rnd_lat = 1'b0;

        // Withheld bin 7: 7 bins * 3 + REQ, then 16 waiting cycles
        set_hist(2);
        bad_en = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 37) begin
                chk("tmo_err_before", 32'(rd_err), 32'd0);
                chk("tmo_busy_before", 32'(busy), 32'd1);
            end
        end
        chk("tmo_rd_err", 32'(rd_err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_ready_kept", 32'(lut_ready), 32'd1);
        bad_en = 1'b0;
        if (SINGLE)
            for (int b = 0; b < 7; b++) mdl_lut[b] = nxt_lut[b];
        sweep();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("restart_clears_err", 32'(rd_err), 32'd0);
        wait_idle(2000);
        commit_model();
        sweep();

        // Reset while sweeping bin 100
        set_hist(2);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (301) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_ready = 1'b0;
        exp_prev = 8'd0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(lut_ready), 32'd0);
        chk("midrst_pixel", 32'(bus.out_pixel), 32'd0);
        for (int i = 0; i < 40; i++) rnd_cyc(1'b0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
